// File: rtl/addsub_rs_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_rs_unit_pkg
//  Description : Shared definitions for the reservation-station execution
//                units: opcode encodings, the "no producer" tag, default
//                datapath widths, the reservation-station entry record and
//                the CDB tag-match helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package addsub_rs_unit_pkg;

    // Default datapath widths; the entry record below is sized by these.
    localparam int RS_DATA_W = 8;
    localparam int RS_TAG_W  = 4;

    // Opcode encodings shared by every functional unit.
    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b0001;
    localparam logic [3:0] MUL  = 4'b0010;
    localparam logic [3:0] DIV  = 4'b0011;
    localparam logic [3:0] LD   = 4'b0100;
    localparam logic [3:0] ST   = 4'b0101;
    localparam logic [3:0] BEQ  = 4'b0110;
    localparam logic [3:0] BNEQ = 4'b0111;

    // Tag 0 is never allocated to a producer.
    localparam logic [RS_TAG_W-1:0] NO_TAG = '0;

    // One reservation-station slot.
    typedef struct packed {
        logic                 busy;
        logic                 executing;
        logic [3:0]           func;
        logic [3:0]           rdest;
        logic                 s1_rdy;
        logic [RS_DATA_W-1:0] s1_val;
        logic [RS_TAG_W-1:0]  s1_tag;
        logic                 s2_rdy;
        logic [RS_DATA_W-1:0] s2_val;
        logic [RS_TAG_W-1:0]  s2_tag;
    } rs_entry_t;

    // A broadcast only wakes an operand when it is valid, carries a real
    // producer tag, and that tag is the one the operand waits on.
    function automatic logic cdb_match(
        input logic                cdb_valid,
        input logic [RS_TAG_W-1:0] cdb_tag,
        input logic [RS_TAG_W-1:0] tag
    );
        return cdb_valid && (cdb_tag != NO_TAG) && (cdb_tag == tag);
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_rs_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_rs_unit_if
//  Description : Issue, common-data-bus and result-offer signals of the
//                add/sub reservation station.
//  Modports    : master - issue stage / CDB / arbiter side
//                slave  - reservation-station unit side
//  Revision    : 1.0 - initial release
// ============================================================================
interface addsub_rs_unit_if #(
    parameter int DATA_W = addsub_rs_unit_pkg::RS_DATA_W,
    parameter int TAG_W  = addsub_rs_unit_pkg::RS_TAG_W
);
    // issue
    logic              issue_valid;
    logic              issue_ready;
    logic [TAG_W-1:0]  issue_tag;
    logic [3:0]        issue_func;
    logic [3:0]        issue_rdest;
    logic              issue_src1_rdy;
    logic [DATA_W-1:0] issue_src1_val;
    logic [TAG_W-1:0]  issue_src1_tag;
    logic              issue_src2_rdy;
    logic [DATA_W-1:0] issue_src2_val;
    logic [TAG_W-1:0]  issue_src2_tag;
    // common data bus
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    // result offer
    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_tag;
    logic [3:0]        out_rdest;
    logic [DATA_W-1:0] out_data;

    modport master (
        output issue_valid, issue_func, issue_rdest,
               issue_src1_rdy, issue_src1_val, issue_src1_tag,
               issue_src2_rdy, issue_src2_val, issue_src2_tag,
               cdb_valid, cdb_tag, cdb_data, out_ready,
        input  issue_ready, issue_tag, out_valid, out_tag, out_rdest, out_data
    );

    modport slave (
        input  issue_valid, issue_func, issue_rdest,
               issue_src1_rdy, issue_src1_val, issue_src1_tag,
               issue_src2_rdy, issue_src2_val, issue_src2_tag,
               cdb_valid, cdb_tag, cdb_data, out_ready,
        output issue_ready, issue_tag, out_valid, out_tag, out_rdest, out_data
    );

endinterface
`default_nettype wire

// File: rtl/addsub_rs_unit_rs_entry_snoop.sv
`default_nettype none
// ============================================================================
//  Module      : rs_entry_snoop
//  Description : Next-state of one reservation-station entry for issue and
//                operand capture. On load the entry is written from the issue
//                fields, with a same-cycle CDB hit bypassed into a waiting
//                operand. Otherwise a busy entry's non-ready operands capture
//                the CDB value on a tag match. Dispatch and release are
//                applied by the parent on top of this result.
//  Ports       : i_entry_q        current entry state
//                i_load           this entry accepts the issuing instruction
//                i_issue_*        decoded instruction fields
//                i_cdb_*          common data bus
//                o_entry_nxt      entry state after issue / capture
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_entry_snoop
    import addsub_rs_unit_pkg::*;
(
    input  rs_entry_t            i_entry_q,
    input  logic                 i_load,
    input  logic [3:0]           i_issue_func,
    input  logic [3:0]           i_issue_rdest,
    input  logic                 i_issue_src1_rdy,
    input  logic [RS_DATA_W-1:0] i_issue_src1_val,
    input  logic [RS_TAG_W-1:0]  i_issue_src1_tag,
    input  logic                 i_issue_src2_rdy,
    input  logic [RS_DATA_W-1:0] i_issue_src2_val,
    input  logic [RS_TAG_W-1:0]  i_issue_src2_tag,
    input  logic                 i_cdb_valid,
    input  logic [RS_TAG_W-1:0]  i_cdb_tag,
    input  logic [RS_DATA_W-1:0] i_cdb_data,
    output rs_entry_t            o_entry_nxt
);

    logic w_byp1;
    logic w_byp2;
    logic w_snp1;
    logic w_snp2;

    always_comb begin
        w_byp1 = !i_issue_src1_rdy && cdb_match(i_cdb_valid, i_cdb_tag, i_issue_src1_tag);
        w_byp2 = !i_issue_src2_rdy && cdb_match(i_cdb_valid, i_cdb_tag, i_issue_src2_tag);
        w_snp1 = i_entry_q.busy && !i_entry_q.s1_rdy
                 && cdb_match(i_cdb_valid, i_cdb_tag, i_entry_q.s1_tag);
        w_snp2 = i_entry_q.busy && !i_entry_q.s2_rdy
                 && cdb_match(i_cdb_valid, i_cdb_tag, i_entry_q.s2_tag);

        o_entry_nxt = i_entry_q;
        if (i_load) begin
            o_entry_nxt.busy      = 1'b1;
            o_entry_nxt.executing = 1'b0;
            o_entry_nxt.func      = i_issue_func;
            o_entry_nxt.rdest     = i_issue_rdest;
            o_entry_nxt.s1_rdy    = i_issue_src1_rdy || w_byp1;
            o_entry_nxt.s1_val    = w_byp1 ? i_cdb_data : i_issue_src1_val;
            o_entry_nxt.s1_tag    = i_issue_src1_tag;
            o_entry_nxt.s2_rdy    = i_issue_src2_rdy || w_byp2;
            o_entry_nxt.s2_val    = w_byp2 ? i_cdb_data : i_issue_src2_val;
            o_entry_nxt.s2_tag    = i_issue_src2_tag;
        end else begin
            // Both operands may wake from the same broadcast.
            if (w_snp1) begin
                o_entry_nxt.s1_rdy = 1'b1;
                o_entry_nxt.s1_val = i_cdb_data;
            end
            if (w_snp2) begin
                o_entry_nxt.s2_rdy = 1'b1;
                o_entry_nxt.s2_val = i_cdb_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/addsub_rs_unit.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_rs_unit
//  Description : Add/subtract reservation station with its multi-cycle
//                adder. Holds RS_DEPTH entries that wait on the CDB for their
//                operands, dispatches the lowest ready entry into the adder
//                one at a time, and offers each result for broadcast under
//                the owning entry's tag.
//  Ports       : clock1   rising-edge clock
//                reset_n  synchronous active-low reset
//                flush    discard all entries and any in-flight operation
//                bus      issue / CDB / result signals (slave side)
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_rs_unit
    import addsub_rs_unit_pkg::*;
#(
    parameter int RS_DEPTH = 3,
    parameter int DATA_W   = RS_DATA_W,
    parameter int TAG_W    = RS_TAG_W,
    parameter int TAG_BASE = 1,
    parameter int EXEC_LAT = 2
)(
    input  wire logic             clock1,
    input  wire logic             reset_n,
    input  wire logic             flush,
    addsub_rs_unit_if.slave       bus
);

    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int CNT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_BCAST = 2'd2;

    rs_entry_t         entries_q [RS_DEPTH];
    rs_entry_t         entries_d [RS_DEPTH];
    rs_entry_t         w_snoop   [RS_DEPTH];

    logic [1:0]        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [IDX_W-1:0]  exec_idx_q,  exec_idx_d;
    logic [DATA_W-1:0] op_a_q,      op_a_d;
    logic [DATA_W-1:0] op_b_q,      op_b_d;
    logic              op_sub_q,    op_sub_d;
    logic              out_valid_q, out_valid_d;
    logic [TAG_W-1:0]  out_tag_q,   out_tag_d;
    logic [3:0]        out_rdest_q, out_rdest_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;

    logic              w_free_found;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_elig_found;
    logic [IDX_W-1:0]  w_elig_idx;
    logic              w_issue_fire;

    // Lowest free slot for issue and lowest ready slot for dispatch, both
    // from registered state. Scanning downward leaves the lowest hit last.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_elig_found = 1'b0;
        w_elig_idx   = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!entries_q[i].busy) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
            if (entries_q[i].busy && entries_q[i].s1_rdy && entries_q[i].s2_rdy
                && !entries_q[i].executing) begin
                w_elig_found = 1'b1;
                w_elig_idx   = IDX_W'(i);
            end
        end
    end

    assign w_issue_fire = bus.issue_valid && w_free_found && !flush;

    assign bus.issue_ready = w_free_found;
    assign bus.issue_tag   = w_free_found ? (TAG_W'(TAG_BASE) + TAG_W'(w_free_idx)) : '0;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.out_rdest   = out_rdest_q;
    assign bus.out_data    = out_data_q;

    generate
        for (genvar g = 0; g < RS_DEPTH; g++) begin : g_entry
            rs_entry_snoop u_snoop (
                .i_entry_q        (entries_q[g]),
                .i_load           (w_issue_fire && (w_free_idx == IDX_W'(g))),
                .i_issue_func     (bus.issue_func),
                .i_issue_rdest    (bus.issue_rdest),
                .i_issue_src1_rdy (bus.issue_src1_rdy),
                .i_issue_src1_val (bus.issue_src1_val),
                .i_issue_src1_tag (bus.issue_src1_tag),
                .i_issue_src2_rdy (bus.issue_src2_rdy),
                .i_issue_src2_val (bus.issue_src2_val),
                .i_issue_src2_tag (bus.issue_src2_tag),
                .i_cdb_valid      (bus.cdb_valid),
                .i_cdb_tag        (bus.cdb_tag),
                .i_cdb_data       (bus.cdb_data),
                .o_entry_nxt      (w_snoop[g])
            );
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        exec_idx_d  = exec_idx_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_sub_d    = op_sub_q;
        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;
        out_rdest_d = out_rdest_q;
        out_data_d  = out_data_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            entries_d[i] = w_snoop[i];
        end

        case (state_q)
            S_IDLE: begin
                if (w_elig_found) begin
                    state_d    = S_EXEC;
                    cnt_d      = CNT_W'(EXEC_LAT - 1);
                    exec_idx_d = w_elig_idx;
                    op_a_d     = entries_q[w_elig_idx].s1_val;
                    op_b_d     = entries_q[w_elig_idx].s2_val;
                    // Only func[0] selects the operation.
                    op_sub_d   = entries_q[w_elig_idx].func[0];
                    entries_d[w_elig_idx].executing = 1'b1;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    state_d     = S_BCAST;
                    out_valid_d = 1'b1;
                    out_tag_d   = TAG_W'(TAG_BASE) + TAG_W'(exec_idx_q);
                    out_rdest_d = entries_q[exec_idx_q].rdest;
                    out_data_d  = op_sub_q ? (op_a_q - op_b_q) : (op_a_q + op_b_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_BCAST: begin
                // The slot is released here; issue sees it free next cycle
                // because issue selection looks at registered state.
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    out_tag_d   = '0;
                    out_rdest_d = '0;
                    out_data_d  = '0;
                    entries_d[exec_idx_q] = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock1) begin
        if (!reset_n || flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            exec_idx_q  <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_sub_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_rdest_q <= '0;
            out_data_q  <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exec_idx_q  <= exec_idx_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_sub_q    <= op_sub_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_rdest_q <= out_rdest_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < RS_DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addsub_rs_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_rs_unit
//  Description : Self-checking bench for addsub_rs_unit. A vector table of
//                ready-operand add/sub instructions, followed by hand-written
//                sequences for CDB wake-up, issue bypass, full station,
//                held broadcast with a dependent entry, reset and flush.
//                The bench acts as CDB: the unit's own accepted result is
//                looped back, plus manually driven broadcasts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_rs_unit;
    import addsub_rs_unit_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    addsub_rs_unit_if #(.DATA_W(8), .TAG_W(4)) bus ();

    logic       man_valid;
    logic [3:0] man_tag;
    logic [7:0] man_data;
    logic       own_fire;

    assign own_fire      = bus.out_valid && bus.out_ready;
    assign bus.cdb_valid = own_fire || man_valid;
    assign bus.cdb_tag   = own_fire ? bus.out_tag  : man_tag;
    assign bus.cdb_data  = own_fire ? bus.out_data : man_data;

    addsub_rs_unit #(
        .RS_DEPTH (3),
        .DATA_W   (8),
        .TAG_W    (4),
        .TAG_BASE (1),
        .EXEC_LAT (2)
    ) dut (
        .clock1  (clk),
        .reset_n (rst_n),
        .flush   (flush),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0] func;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] rdest;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [6];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_issue(input logic [3:0] func, input logic [3:0] rdest,
                             input logic r1, input logic [7:0] v1, input logic [3:0] t1,
                             input logic r2, input logic [7:0] v2, input logic [3:0] t2);
        bus.issue_func     = func;
        bus.issue_rdest    = rdest;
        bus.issue_src1_rdy = r1;
        bus.issue_src1_val = v1;
        bus.issue_src1_tag = t1;
        bus.issue_src2_rdy = r2;
        bus.issue_src2_val = v2;
        bus.issue_src2_tag = t2;
    endtask

    // Ticks until out_valid is seen or the budget runs out; n = ticks taken.
    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;

        vecs[0] = '{func: ADD,     a: 8'h05, b: 8'h03, rdest: 4'd4,  exp: 8'h08};
        vecs[1] = '{func: SUB,     a: 8'h02, b: 8'h05, rdest: 4'd2,  exp: 8'hFD};
        vecs[2] = '{func: ADD,     a: 8'hFF, b: 8'h02, rdest: 4'd7,  exp: 8'h01};
        vecs[3] = '{func: SUB,     a: 8'h80, b: 8'h01, rdest: 4'd3,  exp: 8'h7F};
        vecs[4] = '{func: 4'b1110, a: 8'h10, b: 8'h20, rdest: 4'd12, exp: 8'h30};
        vecs[5] = '{func: 4'b0011, a: 8'h00, b: 8'h01, rdest: 4'd15, exp: 8'hFF};

        bus.issue_valid = 1'b0;
        bus.out_ready   = 1'b1;
        man_valid       = 1'b0;
        man_tag         = '0;
        man_data        = '0;
        set_issue(ADD, 4'd0, 1'b1, 8'h00, 4'd0, 1'b1, 8'h00, 4'd0);

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_out_valid",   bus.out_valid,   0);
        chk("rst_out_tag",     bus.out_tag,     0);
        chk("rst_out_rdest",   bus.out_rdest,   0);
        chk("rst_out_data",    bus.out_data,    0);
        chk("rst_issue_ready", bus.issue_ready, 1);
        chk("rst_issue_tag",   bus.issue_tag,   1);

        // ---------------- vector table ----------------
        for (int k = 0; k < 6; k++) begin
            set_issue(vecs[k].func, vecs[k].rdest, 1'b1, vecs[k].a, 4'd0,
                      1'b1, vecs[k].b, 4'd0);
            chk($sformatf("vec%0d_issue_ready", k), bus.issue_ready, 1);
            chk($sformatf("vec%0d_issue_tag", k),   bus.issue_tag,   1);
            bus.issue_valid = 1'b1;
            tick();
            bus.issue_valid = 1'b0;
            wait_out(n);
            chk($sformatf("vec%0d_latency", k), n,             3);
            chk($sformatf("vec%0d_data", k),    bus.out_data,  vecs[k].exp);
            chk($sformatf("vec%0d_tag", k),     bus.out_tag,   1);
            chk($sformatf("vec%0d_rdest", k),   bus.out_rdest, vecs[k].rdest);
            tick();
            chk($sformatf("vec%0d_released", k), bus.out_valid, 0);
        end

        // ---------------- CDB wake-up ----------------
        set_issue(ADD, 4'd5, 1'b0, 8'h00, 4'd7, 1'b1, 8'h05, 4'd0);
        bus.issue_valid = 1'b1;
        tick();
        bus.issue_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("snoop_not_dispatched", bus.out_valid, 0);
        man_valid = 1'b1;
        man_tag   = 4'd7;
        man_data  = 8'h10;
        tick();
        man_valid = 1'b0;
        wait_out(n);
        chk("snoop_latency", n,             3);
        chk("snoop_data",    bus.out_data,  8'h15);
        chk("snoop_tag",     bus.out_tag,   1);
        chk("snoop_rdest",   bus.out_rdest, 5);
        tick();

        // ---------------- bypass in the issue cycle ----------------
        set_issue(ADD, 4'd10, 1'b0, 8'h00, 4'd7, 1'b1, 8'h03, 4'd0);
        man_valid       = 1'b1;
        man_tag         = 4'd7;
        man_data        = 8'h20;
        bus.issue_valid = 1'b1;
        tick();
        bus.issue_valid = 1'b0;
        man_valid       = 1'b0;
        wait_out(n);
        chk("bypass_latency", n,            3);
        chk("bypass_data",    bus.out_data, 8'h23);
        chk("bypass_tag",     bus.out_tag,  1);
        tick();

        // ---------------- full station ----------------
        for (int k = 0; k < 3; k++) begin
            set_issue(ADD, 4'(k + 1), 1'b0, 8'h00, 4'(9 + k), 1'b1, 8'h20, 4'd0);
            chk($sformatf("full_issue%0d_tag", k), bus.issue_tag, k + 1);
            bus.issue_valid = 1'b1;
            tick();
            bus.issue_valid = 1'b0;
        end
        chk("full_ready_low", bus.issue_ready, 0);
        set_issue(ADD, 4'd8, 1'b1, 8'h40, 4'd0, 1'b1, 8'h01, 4'd0);
        bus.issue_valid = 1'b1;
        tick();
        tick();
        chk("full_held", bus.issue_ready, 0);
        man_valid = 1'b1;
        man_tag   = 4'd10;
        man_data  = 8'h01;
        tick();
        man_valid = 1'b0;
        wait_out(n);
        chk("full_free_latency", n,               3);
        chk("full_free_tag",     bus.out_tag,     2);
        chk("full_free_data",    bus.out_data,    8'h21);
        chk("full_still_full",   bus.issue_ready, 0);
        tick();
        chk("full_ready_after_accept", bus.issue_ready, 1);
        chk("full_reused_tag",         bus.issue_tag,   2);
        tick();
        bus.issue_valid = 1'b0;
        chk("full_again", bus.issue_ready, 0);
        wait_out(n);
        chk("full_new_latency", n,             3);
        chk("full_new_tag",     bus.out_tag,   2);
        chk("full_new_data",    bus.out_data,  8'h41);
        chk("full_new_rdest",   bus.out_rdest, 8);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("full_flush_ready", bus.issue_ready, 1);
        chk("full_flush_tag",   bus.issue_tag,   1);

        // ---------------- held broadcast + dependent ----------------
        bus.out_ready = 1'b0;
        set_issue(ADD, 4'd1, 1'b1, 8'h01, 4'd0, 1'b1, 8'h02, 4'd0);
        bus.issue_valid = 1'b1;
        tick();
        set_issue(SUB, 4'd6, 1'b0, 8'h00, 4'd1, 1'b1, 8'h01, 4'd0);
        chk("dep_issue_tag", bus.issue_tag, 2);
        tick();
        bus.issue_valid = 1'b0;
        wait_out(n);
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data",  bus.out_data,  8'h03);
        chk("hold_tag",   bus.out_tag,   1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("hold_stable%0d", k),
                {bus.out_valid, bus.out_tag, bus.out_rdest, bus.out_data},
                {1'b1, 4'd1, 4'd1, 8'h03});
        end
        bus.out_ready = 1'b1;
        tick();
        chk("hold_accepted", bus.out_valid, 0);
        wait_out(n);
        chk("dep_latency", n,             3);
        chk("dep_data",    bus.out_data,  8'h02);
        chk("dep_tag",     bus.out_tag,   2);
        chk("dep_rdest",   bus.out_rdest, 6);
        tick();

        // ---------------- reset during EXEC ----------------
        set_issue(ADD, 4'd9, 1'b1, 8'h11, 4'd0, 1'b1, 8'h22, 4'd0);
        bus.issue_valid = 1'b1;
        tick();
        bus.issue_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rstx_out_valid",   bus.out_valid,   0);
        chk("rstx_out_data",    bus.out_data,    0);
        chk("rstx_issue_ready", bus.issue_ready, 1);
        chk("rstx_issue_tag",   bus.issue_tag,   1);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        chk("rstx_no_stale", seen, 0);

        // ---------------- flush during EXEC ----------------
        set_issue(SUB, 4'd9, 1'b1, 8'h33, 4'd0, 1'b1, 8'h11, 4'd0);
        bus.issue_valid = 1'b1;
        tick();
        bus.issue_valid = 1'b0;
        tick();
        tick();
        flush           = 1'b1;
        bus.issue_valid = 1'b1;
        tick();
        flush           = 1'b0;
        bus.issue_valid = 1'b0;
        chk("flx_out_valid",   bus.out_valid,   0);
        chk("flx_issue_ready", bus.issue_ready, 1);
        chk("flx_issue_tag",   bus.issue_tag,   1);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        chk("flx_no_stale",      seen,          0);
        chk("flx_issue_ignored", bus.issue_tag, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/addsub_rs_unit.md
Name: addsub_rs_unit

Overview:
- Add/subtract reservation station plus its execution unit.
- Sits directly downstream of the issue stage.
- Accepts decoded add/sub instructions with operands that are either values or producer tags. Snoops the common data bus (CDB) until both operands are present, then dispatches one entry at a time to a multi-cycle adder.
- Broadcasts each result on the CDB under the entry's tag.

Parameters:
- RS_DEPTH, 3: number of reservation-station entries.
- DATA_W, 8: operand/result width.
- TAG_W, 4: tag and register-index width.
- TAG_BASE, 1: tag of entry 0; entry i owns tag TAG_BASE+i. Tag 0 is never issued and means "no producer".
- EXEC_LAT, 2: cycles from dispatch to result (≥1).

Ports:
- clock1 in 1: sole clock, rising edge.
- reset_n in 1: synchronous, active-low reset.
- issue_valid in 1: issue stage presents an instruction.
- issue_ready out 1: a free entry exists.
- issue_tag out TAG_W: tag the accepted instruction receives (lowest free entry); valid while issue_ready.
- issue_func in 4: 0000 add, 0001 subtract.
- issue_rdest in 4: destination register.
- issue_src1_rdy in 1: src1 value valid; else wait on issue_src1_tag.
- issue_src1_val in DATA_W: src1 value.
- issue_src1_tag in TAG_W: src1 producer tag.
- issue_src2_rdy, issue_src2_val, issue_src2_tag: same for src2.
- cdb_valid in 1: CDB broadcast present (any unit, including this one).
- cdb_tag in TAG_W: broadcast tag.
- cdb_data in DATA_W: broadcast value.
- out_valid out 1: result offered to CDB arbiter.
- out_ready in 1: arbiter accepts the result.
- out_tag out TAG_W: producing entry tag.
- out_rdest out 4: destination register.
- out_data out DATA_W: result.
- flush in 1: discard all entries and any in-flight op.

Behaviour:
- Reset (reset_n=0 at edge):
  - All entries invalid; FSM to IDLE; exec counter 0.
  - out_valid=0, out_tag/out_rdest/out_data=0.
  - Overrides every other input, including mid-execution and mid-broadcast.
- flush=1 at edge: same effect as reset. issue_valid in that cycle is ignored.
- Entry fields: busy, executing, func, rdest, s1_rdy/s1_val/s1_tag, s2_rdy/s2_val/s2_tag.
- Issue:
  - Handshake is issue_valid && issue_ready at the edge; fills the lowest-index free entry.
  - issue_ready = any entry not busy, evaluated on registered state. Full means issue_ready=0; the instruction is held upstream.
  - Freeing an entry and issuing into it in the same cycle is not allowed; the slot is visible next cycle.
- Bypass at issue: if an operand is not ready but cdb_valid && cdb_tag equals its tag in the same cycle, capture cdb_data and mark it ready.
- CDB snoop: every busy entry with a non-ready operand whose tag matches a valid cdb_tag captures cdb_data at that edge. Both operands may capture from one broadcast.
- Dispatch:
  - Eligible entry: busy, both operands ready, not executing, based on registered state.
  - In IDLE, the lowest-index eligible entry is dispatched at the edge. Its operands are latched into the adder and it is marked executing.
  - An operand captured at edge N makes the entry eligible at edge N+1.
- FSM:
  - IDLE → EXEC on dispatch.
  - EXEC counts EXEC_LAT cycles, then moves to BCAST with the result registered.
  - BCAST holds out_valid=1 with stable tag/rdest/data until out_ready. On the accepting edge the entry is freed and FSM → IDLE.
  - No dispatch while in EXEC or BCAST.
  - out_valid rises exactly EXEC_LAT cycles after the dispatch edge.
- Arithmetic:
  - func[0]=0 computes src1+src2; func[0]=1 computes src1−src2.
  - Modulo 2^DATA_W: carry/borrow discarded, wrap-around.
  - func[3:1] ignored.
- Own broadcast: the out_* value returns via cdb_*, and dependent entries in this RS capture it like any other broadcast.
- cdb_tag 0 never matches; operands with rdy=1 never snoop.

Decomposition:
- Shared package holds:
  - Opcode constants: ADD=4'b0000, SUB=4'b0001, MUL, DIV, LD, ST, BEQ, BNEQ.
  - NO_TAG=0.
  - Default DATA_W/TAG_W.
  - RS entry struct typedef, reused by the multiplier RS.
- One sub-module, rs_entry_snoop: a single entry's operand-capture/issue-bypass logic, instantiated RS_DEPTH times.
- Selection, FSM and the adder stay in the top.

Test Plan:
- Reset then issue ADD src1=8'h05, src2=8'h03, both ready, rdest=4 → issue_tag=1; out_valid 2 cycles after dispatch with data 8'h08, tag 1, rdest 4.
- SUB 8'h02−8'h05 → out_data 8'hFD. ADD 8'hFF+8'h02 → 8'h01.
- Issue ADD with src1 waiting on tag 7, then cdb_valid tag 7 data 8'h10 → captured; dispatch next cycle; result = 8'h10+src2. Repeat with the CDB match in the issue cycle itself (bypass).
- Fill 3 entries with unresolved tags → issue_ready=0 and a 4th issue_valid is held. Free one via broadcast accept → issue_ready=1 the next cycle, and the new entry gets the freed tag.
- Hold out_ready=0 for 5 cycles in BCAST → out_* stable, no new dispatch. Dependent entry on tag 1 resolves when the own broadcast appears on cdb_*.
- Assert reset_n=0 (and separately flush=1) during EXEC → next cycle out_valid=0, issue_ready=1, no stale result ever broadcast.
